alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, registered ALU. It generalises the existing 4-bit, 4-op ALU to WIDTH-bit operands and 8 operations.
- Adds a ready/valid accept handshake, zero and carry flags, and a multi-cycle shift-add multiplier.
- Sits between the operand/decode stage and the writeback stage of the datapath.

Parameters:
- WIDTH, 4, operand width in bits (>=2). Result width is 2*WIDTH.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- en  input  1  operation request; accepted at a rising edge when en && ready.
- ready  output  1  block can accept an operation this cycle.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- ctrl  input  3  operation select.
- out  output  2*WIDTH  registered result.
- valid  output  1  one-cycle pulse; out/zero/carry are new this cycle.
- zero  output  1  registered, out == 0 for the current result.
- carry  output  1  registered carry/borrow for the current result.

Behaviour:
- Reset (asynchronous, while rst=1):
  - out=0, valid=0, zero=0, carry=0.
  - FSM=IDLE; multiplier registers cleared.
  - en is ignored while rst=1.
- ready = (state == IDLE). It is combinational from state.
- Operand capture:
  - a, b and ctrl are sampled only at the accept edge.
  - Later changes have no effect on the operation in flight.
- Ops. Upper result bits are zero unless stated.
  - 000 ADD: out = a+b, zero-extended; carry = bit WIDTH of the sum.
  - 001 SUB: out[WIDTH-1:0] = (a-b) mod 2^WIDTH; carry = borrow (a<b).
  - 010 MUL: out = a*b, full 2*WIDTH bits, multi-cycle; carry = 0.
  - 011 AND, 100 OR, 101 XOR: bitwise on the low WIDTH bits; carry = 0.
  - 110 SHL: out = {WIDTH'b0,a} << b. If b >= 2*WIDTH, out = 0. carry = 0.
  - 111 CMP: out[0]=a<b, out[1]=a==b, out[2]=a>b; carry = 0.
- Single-cycle ops (all except MUL):
  - The result is registered at the accept edge; valid=1 for the following cycle.
  - ready stays 1, so throughput is one op per cycle.
- MUL FSM (IDLE -> MUL -> IDLE):
  - Accept edge: load multiplicand, multiplier and a zeroed accumulator; count=WIDTH; go to MUL.
  - In MUL: ready=0. Each edge adds the shifted multiplicand when the multiplier LSB=1, shifts, and decrements count.
  - On the edge where count reaches 0: write out/zero/carry, assert valid, return to IDLE.
  - valid appears WIDTH cycles after the accept edge. ready returns to 1 in the same cycle valid is high, so a new op may be accepted in that cycle.
- valid:
  - Deasserts at the next edge unless another single-cycle op or MUL completion occurs at that edge.
  - out, zero and carry hold their last values when valid=0.
- en=1 while ready=0: ignored. The request is not queued.
- en=0 in IDLE: no accept; outputs hold; valid falls to 0.
- Reset mid-MUL: the operation is aborted and discarded, with no valid. After rst falls, ready=1 and the first edge with en=1 is accepted normally.

Test Plan (WIDTH=4):
1. ADD a=14, b=7, en=1 for one cycle -> the next cycle has out=0x15, carry=1, zero=0, valid=1 for exactly 1 cycle.
2. SUB a=14, b=7 -> out=0x07, carry=0. Then back-to-back SUB a=7, b=14 -> out=0x09, carry=1 on consecutive valid cycles, with ready constantly 1.
3. MUL a=14, b=7:
   - ready=0 for 4 cycles; a/b are changed to 0 mid-op and en is held high.
   - Result: out=0x62, valid after 4 edges, no extra accepts.
   - Then MUL 12*6 accepted in the valid cycle -> out=0x48 four cycles later.
4. Logic and compare with a=14, b=7:
   - AND -> 0x06; OR -> 0x0F; XOR -> 0x09; CMP -> 0x04.
   - SHL a=14, b=3 -> 0x70; SHL b=8 -> 0x00 with zero=1.
5. Reset 2 cycles into MUL 14*7 -> out=0, valid=0 and no late valid. ready=1 after release; ADD 1+1 -> out=0x02.
6. en=0 after an ADD result -> valid falls to 0 and out holds 0x15 over 5 cycles. Reset asserted asynchronously between edges clears outputs immediately.

Source files
------------

// File: rtl/alu_seq.sv
// Registered WIDTH-bit ALU with ready/valid accept, zero/carry flags and a
// multi-cycle shift-add multiplier.
module alu_seq #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  output logic                 ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [2:0]           ctrl,
  output logic [2*WIDTH-1:0]   out,
  output logic                 valid,
  output logic                 zero,
  output logic                 carry
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH:0] SHL_LIM = (WIDTH + 1)'(2 * WIDTH);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_MUL = 3'b010,
    OP_AND = 3'b011,
    OP_OR  = 3'b100,
    OP_XOR = 3'b101,
    OP_SHL = 3'b110,
    OP_CMP = 3'b111
  } op_t;

  typedef enum logic {
    S_IDLE,
    S_MUL
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [2*WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [2*WIDTH-1:0]   r_acc;
  logic [CW-1:0]        r_cnt;

  logic [WIDTH:0]       w_sum;
  logic [WIDTH:0]       w_diff;
  logic [2*WIDTH-1:0]   w_shl;
  logic [2*WIDTH-1:0]   w_res;
  logic                 w_carry;
  logic [2*WIDTH-1:0]   w_acc_nxt;
  logic                 w_accept;
  logic                 w_is_mul;
  logic                 w_mul_done;

  assign w_sum      = {1'b0, a} + {1'b0, b};
  assign w_diff     = {1'b0, a} - {1'b0, b};
  assign w_shl      = {{WIDTH{1'b0}}, a} << b;
  assign w_acc_nxt  = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_is_mul   = (op_t'(ctrl) == OP_MUL);
  assign w_accept   = en && ready;
  assign w_mul_done = (r_state == S_MUL) && (r_cnt == CW'(1));

  always_comb begin
    w_res   = '0;
    w_carry = 1'b0;
    case (op_t'(ctrl))
      OP_ADD: begin
        w_res   = {{(WIDTH-1){1'b0}}, w_sum};
        w_carry = w_sum[WIDTH];
      end
      OP_SUB: begin
        w_res   = {{WIDTH{1'b0}}, w_diff[WIDTH-1:0]};
        w_carry = w_diff[WIDTH];
      end
      OP_AND: w_res = {{WIDTH{1'b0}}, a & b};
      OP_OR:  w_res = {{WIDTH{1'b0}}, a | b};
      OP_XOR: w_res = {{WIDTH{1'b0}}, a ^ b};
      OP_SHL: w_res = ({1'b0, b} >= SHL_LIM) ? '0 : w_shl;
      OP_CMP: w_res = {{(2*WIDTH-3){1'b0}}, (a > b), (a == b), (a < b)};
      default: w_res = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    ready       = (r_state == S_IDLE);
    case (r_state)
      S_IDLE:  if (en && w_is_mul) w_state_nxt = S_MUL;
      S_MUL:   if (r_cnt == CW'(1)) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out      <= '0;
      valid    <= 1'b0;
      zero     <= 1'b0;
      carry    <= 1'b0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else begin
      valid <= 1'b0;
      if (w_accept) begin
        if (w_is_mul) begin
          r_mcand  <= {{WIDTH{1'b0}}, a};
          r_mplier <= b;
          r_acc    <= '0;
          r_cnt    <= CW'(WIDTH);
        end else begin
          out   <= w_res;
          zero  <= (w_res == '0);
          carry <= w_carry;
          valid <= 1'b1;
        end
      end else if (r_state == S_MUL) begin
        // One partial product per edge; the last edge publishes the sum directly.
        r_acc    <= w_acc_nxt;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt - CW'(1);
        if (w_mul_done) begin
          out   <= w_acc_nxt;
          zero  <= (w_acc_nxt == '0);
          carry <= 1'b0;
          valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq at WIDTH=4 with hand-computed results.
module tb_alu_seq;

  localparam int W = 4;

  logic           clk;
  logic           rst;
  logic           en;
  logic           ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic [2:0]     ctrl;
  logic [2*W-1:0] out;
  logic           valid;
  logic           zero;
  logic           carry;

  int n_checks;
  int n_fail;

  localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, MUL = 3'b010, AND_ = 3'b011,
                         OR_ = 3'b100, XOR_ = 3'b101, SHL = 3'b110, CMP = 3'b111;

  alu_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .ready (ready),
    .a     (a),
    .b     (b),
    .ctrl  (ctrl),
    .out   (out),
    .valid (valid),
    .zero  (zero),
    .carry (carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive(input logic e, input logic [2:0] op, input logic [W-1:0] va,
                       input logic [W-1:0] vb);
    en = e; ctrl = op; a = va; b = vb;
  endtask

  task automatic check_res(input string tag, input logic [2*W-1:0] eo, input logic ec,
                           input logic ez);
    check_eq({tag, ".valid"}, 32'(valid), 32'd1);
    check_eq({tag, ".out"},   32'(out),   32'(eo));
    check_eq({tag, ".carry"}, 32'(carry), 32'(ec));
    check_eq({tag, ".zero"},  32'(zero),  32'(ez));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    drive(1'b1, ADD, 4'd3, 4'd3);
    tick(); tick();
    check_eq("rst.out",   32'(out),   32'd0);
    check_eq("rst.valid", 32'(valid), 32'd0);
    check_eq("rst.zero",  32'(zero),  32'd0);
    check_eq("rst.carry", 32'(carry), 32'd0);
    check_eq("rst.ready", 32'(ready), 32'd1);
    rst = 1'b0;
    drive(1'b0, ADD, 4'd0, 4'd0);
    tick();

    // ADD, then idle: valid must drop and out hold for 5 cycles
    drive(1'b1, ADD, 4'd14, 4'd7);
    tick();
    drive(1'b0, ADD, 4'd0, 4'd0);
    check_res("add14_7", 8'h15, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("idle.valid", 32'(valid), 32'd0);
      check_eq("idle.out",   32'(out),   32'h15);
    end

    // back-to-back SUB
    drive(1'b1, SUB, 4'd14, 4'd7);
    tick();
    check_res("sub14_7", 8'h07, 1'b0, 1'b0);
    check_eq("sub1.ready", 32'(ready), 32'd1);
    drive(1'b1, SUB, 4'd7, 4'd14);
    tick();
    check_res("sub7_14", 8'h09, 1'b1, 1'b0);
    check_eq("sub2.ready", 32'(ready), 32'd1);
    drive(1'b0, ADD, 4'd0, 4'd0);
    tick();
    check_eq("sub.vfall", 32'(valid), 32'd0);

    // MUL 14*7 with operands disturbed and en held high mid-op
    drive(1'b1, MUL, 4'd14, 4'd7);
    tick();
    drive(1'b1, MUL, 4'd0, 4'd0);
    for (int i = 0; i < 4; i++) begin
      check_eq("mul1.ready", 32'(ready), 32'd0);
      check_eq("mul1.valid", 32'(valid), 32'd0);
      tick();
    end
    check_res("mul14_7", 8'h62, 1'b0, 1'b0);
    check_eq("mul1.rdy_done", 32'(ready), 32'd1);
    drive(1'b1, MUL, 4'd12, 4'd6);
    tick();
    drive(1'b0, ADD, 4'd0, 4'd0);
    for (int i = 0; i < 4; i++) begin
      check_eq("mul2.ready", 32'(ready), 32'd0);
      check_eq("mul2.valid", 32'(valid), 32'd0);
      tick();
    end
    check_res("mul12_6", 8'h48, 1'b0, 1'b0);
    tick();
    check_eq("mul2.vfall", 32'(valid), 32'd0);
    check_eq("mul2.hold",  32'(out),   32'h48);
    check_eq("mul2.ready", 32'(ready), 32'd1);

    // logic, compare, shift
    drive(1'b1, AND_, 4'd14, 4'd7); tick(); check_res("and", 8'h06, 1'b0, 1'b0);
    drive(1'b1, OR_,  4'd14, 4'd7); tick(); check_res("or",  8'h0F, 1'b0, 1'b0);
    drive(1'b1, XOR_, 4'd14, 4'd7); tick(); check_res("xor", 8'h09, 1'b0, 1'b0);
    drive(1'b1, CMP,  4'd14, 4'd7); tick(); check_res("cmp_gt", 8'h04, 1'b0, 1'b0);
    drive(1'b1, CMP,  4'd5,  4'd5); tick(); check_res("cmp_eq", 8'h02, 1'b0, 1'b0);
    drive(1'b1, CMP,  4'd2,  4'd9); tick(); check_res("cmp_lt", 8'h01, 1'b0, 1'b0);
    drive(1'b1, SHL,  4'd14, 4'd3); tick(); check_res("shl3", 8'h70, 1'b0, 1'b0);
    drive(1'b1, SHL,  4'd14, 4'd7); tick(); check_res("shl7", 8'h00, 1'b0, 1'b1);
    drive(1'b1, SHL,  4'd14, 4'd8); tick(); check_res("shl8", 8'h00, 1'b0, 1'b1);
    drive(1'b1, ADD,  4'd15, 4'd1); tick(); check_res("add_wrap", 8'h10, 1'b1, 1'b0);

    // reset two cycles into MUL, asserted between edges
    drive(1'b1, ADD, 4'd14, 4'd7); tick(); check_res("pre_mul_add", 8'h15, 1'b1, 1'b0);
    drive(1'b1, MUL, 4'd14, 4'd7);
    tick();
    drive(1'b0, ADD, 4'd0, 4'd0);
    tick();
    tick();
    check_eq("abort.pre_ready", 32'(ready), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    check_eq("arst.out",   32'(out),   32'd0);
    check_eq("arst.valid", 32'(valid), 32'd0);
    check_eq("arst.carry", 32'(carry), 32'd0);
    check_eq("arst.ready", 32'(ready), 32'd1);
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check_eq("abort.novalid", 32'(valid), 32'd0);
      check_eq("abort.ready",   32'(ready), 32'd1);
    end
    drive(1'b1, ADD, 4'd1, 4'd1);
    tick();
    drive(1'b0, ADD, 4'd0, 4'd0);
    check_res("add1_1", 8'h02, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
